mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 25 ++
 rtl/div_step.sv | 35 +++
 rtl/mdu_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared M-extension definitions: operand width and funct3 encodings.
// Latency: none (constants and a pure helper function).
// Backpressure: not applicable.
package mdu_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // Magnitude of v when treated as signed; raw value otherwise.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude for the divider.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 divide iteration: shift, trial subtract, restore, quotient bit.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the outputs.
//   rem_i/quo_i : partial remainder and dividend/quotient shift register in
//   dvsr_i      : divisor magnitude
//   rem_o/quo_o : updated partial remainder and quotient shift register
module div_step
  import mdu_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    // Next dividend bit enters the remainder from the top of quo_i; the
    // freed low bit of quo_i receives the new quotient bit.
    shifted = {rem_i, quo_i[XLEN-1]};
    trial   = shifted - {1'b0, dvsr_i};
    // shifted < 2*divisor, so the extra top bit is a clean borrow flag.
    if (trial[XLEN]) begin
      rem_o = shifted[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// RISC-V M-extension multiply/divide unit sitting in the EXE stage.
// Latency: MUL* 2 cycles, DIV/REM 34 cycles, divide-by-zero/overflow 1 cycle.
// Backpressure: stall_o holds the pipeline until the cycle done_o is high.
//   clk, rst_n      : clock, async active-low reset
//   start_i         : M-type instruction valid in EXE (held while stalled)
//   funct3_i        : operation select
//   rs1_i, rs2_i    : operands
//   stall_o         : to the pipeline controller's mtype_stall
//   done_o          : result_o valid this cycle
//   result_o        : registered result, held until the next completion
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  // Multiplier datapath
  logic              a_sgn, b_sgn;
  logic [2*XLEN-1:0] a_w, b_w, prod;

  // Divider datapath
  logic            div_signed;
  logic [XLEN-1:0] dvsr;
  logic [XLEN-1:0] step_rem, step_quo;
  logic            neg_quo, neg_rem;

  // Special-divide detection on the live inputs (taken straight from IDLE)
  logic in_div_zero, in_div_ovf;

  div_step u_div_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  always_comb begin
    // Equivalent to a 33x33 signed product: each operand is extended by
    // its sign bit (or zero), then widened to 2*XLEN so both halves of
    // the truncated product are exact.
    a_sgn = (f3_q != F3_MULHU) & rs1_q[XLEN-1];
    b_sgn = ~f3_q[1] & rs2_q[XLEN-1];
    a_w   = {{XLEN{a_sgn}}, rs1_q};
    b_w   = {{XLEN{b_sgn}}, rs2_q};
    prod  = a_w * b_w;

    // funct3[0] clear means a signed divide (DIV, REM).
    div_signed = ~f3_q[0];
    dvsr       = abs_val(rs2_q, div_signed);
    neg_quo    = div_signed & (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
    neg_rem    = div_signed & rs1_q[XLEN-1];

    in_div_zero = (rs2_i == '0);
    in_div_ovf  = ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &
                  (rs2_i == '1);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          f3_d  = funct3_i;
          rs1_d = rs1_i;
          rs2_d = rs2_i;
          if (!funct3_i[2]) begin
            state_d = S_MUL;
          end else if (in_div_zero) begin
            // Quotient all ones, remainder is the dividend.
            result_d = funct3_i[1] ? rs1_i : '1;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (in_div_ovf) begin
            // Quotient is the dividend (most negative value), remainder 0.
            result_d = funct3_i[1] ? '0 : rs1_i;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            quo_d   = abs_val(rs1_i, ~funct3_i[0]);
            rem_d   = '0;
            cnt_d   = '0;
            state_d = S_DIV;
          end
        end
      end

      S_MUL: begin
        result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        done_d   = 1'b1;
        state_d  = S_DONE;
      end

      S_DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == 6'd31) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      S_FIX: begin
        if (f3_q[1]) begin
          result_d = neg_rem ? (~rem_q + 1'b1) : rem_q;
        end else begin
          result_d = neg_quo ? (~quo_q + 1'b1) : quo_q;
        end
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      // start_i is deliberately ignored here: the instruction that just
      // completed is still presented while it leaves EXE.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Combinational so the pipeline freezes in the same cycle start_i appears.
  assign stall_o  = ((state_q == S_IDLE) && start_i) ||
                    (state_q == S_MUL) || (state_q == S_DIV) ||
                    (state_q == S_FIX);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed vectors, back-to-back ops,
// mid-operation reset and a short random mix against a reference model.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stall_cnt = 0;

  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];
  int          exp_lat_q[$];
  string       tag_q[$];

  mdu_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference results following the RISC-V M-extension definition.
  function automatic logic [31:0] ref_mdu(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] w;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = a;
    ib = b;
    w  = '0;
    case (f3)
      3'd0: begin w = sa * sb; return w[31:0];  end
      3'd1: begin w = sa * sb; return w[63:32]; end
      3'd2: begin w = sa * ub; return w[63:32]; end
      3'd3: begin w = ua * ub; return w[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int op_latency(input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called on a negedge. When b2b is set the DUT is in DONE of the previous
  // op this cycle, so the new op's cycle 0 is the next one. Returns on the
  // negedge of this op's DONE cycle with start_i still high.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r,
                       input string tag, input bit b2b);
    int  lat;
    int  c0;
    bit  seen;
    lat  = op_latency(f3, a, b);
    c0   = b2b ? cyc + 1 : cyc;
    start_i  = 1'b1;
    funct3_i = f3;
    rs1_i    = a;
    rs2_i    = b;
    exp_res_q.push_back(exp_r);
    exp_cyc_q.push_back(c0 + lat);
    exp_lat_q.push_back(lat);
    tag_q.push_back(tag);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      start_i = 1'b0;
    end
  endtask

  // Scoreboard consumer: compares every completion in order of issue.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
    end else if (done_o) begin
      if (exp_res_q.size() == 0) begin
        check_eq("spurious_done", 32'd1, 32'd0);
      end else begin
        string t;
        t = tag_q.pop_front();
        check_eq(t, result_o, exp_res_q.pop_front());
        check_eq({t, "_cycle"}, cyc, exp_cyc_q.pop_front());
        check_eq({t, "_stall_cycles"}, stall_cnt, exp_lat_q.pop_front());
        check_eq({t, "_stall_in_done"}, {31'd0, stall_o}, 32'd0);
      end
      stall_cnt = 0;
    end else if (stall_o) begin
      stall_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_mdu_ctrl time limit");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;

    rst_n    = 1'b0;
    start_i  = 1'b1;
    funct3_i = 3'd0;
    rs1_i    = 32'd5;
    rs2_i    = 32'd6;
    repeat (2) @(negedge clk);
    check_eq("rst_result", result_o, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_stall_follows_start_hi", {31'd0, stall_o}, 32'd1);
    start_i = 1'b0;
    #1;
    check_eq("rst_stall_follows_start_lo", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3", 1'b0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max", 1'b1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, "mulhsu_m1_2", 1'b1);
    start_i = 1'b0;
    @(negedge clk);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", 1'b0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", 1'b1);
    do_op(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, "divu_by0", 1'b1);
    do_op(3'd6, 32'd100, 32'd0, 32'd100, "rem_by0", 1'b1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf", 1'b1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf", 1'b1);
    start_i = 1'b0;

    // Result must hold after DONE with no new start
    repeat (3) @(negedge clk);
    check_eq("result_hold", result_o, 32'h0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_minmin", 1'b0);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("result_hold_2", result_o, 32'h4000_0000);

    // Reset in the middle of a divide
    start_i  = 1'b1;
    funct3_i = 3'd4;
    rs1_i    = 32'd1000;
    rs2_i    = 32'd7;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_result", result_o, 32'd0);
    check_eq("midrst_done", {31'd0, done_o}, 32'd0);
    check_eq("midrst_stall", {31'd0, stall_o}, 32'd1);
    start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_result", result_o, 32'd0);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, "postrst_mul", 1'b0);
    start_i = 1'b0;
    @(negedge clk);

    // Back-to-back with start_i held through DONE
    do_op(3'd5, 32'd9, 32'd3, 32'd3, "divu_9_3", 1'b0);
    do_op(3'd7, 32'd10, 32'd4, 32'd2, "remu_10_4", 1'b1);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("no_double_exec", exp_res_q.size(), 32'd0);
    check_eq("hold_after_b2b", result_o, 32'd2);

    // Random mix, chained back-to-back
    for (int i = 0; i < 10; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i == 5) b = 32'd0;
      do_op(f3, a, b, ref_mdu(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3),
            (i != 0));
    end
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("sb_empty", exp_res_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
